// File: rtl/proc_control_unit.sv
// Control unit for simple_processor: fetches instruction words from a synchronous ROM,
// decodes them and sequences register-file, accumulator, ALU and G strobes over a shared bus.
module proc_control_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_addr,
    input  logic                  reset,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  IR_in,
    output logic [7:0]            R_in,
    output logic [7:0]            R_out,
    output logic                  DIN_out,
    output logic                  G_out,
    output logic                  A_in,
    output logic                  G_in,
    output logic [1:0]            alu_op,
    output logic                  done,
    output logic                  halted
);

    typedef enum logic [2:0] {FETCH, DECODE, T1, T2, T3, HALT} state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t     state;
    logic [8:0] ir;
    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       is_alu;
    logic       unused_din;

    // Only the opcode/X/Y fields of an instruction word matter; the rest is ignored.
    assign unused_din = ^DIN;
    assign opcode     = ir[8:6];
    assign rx         = ir[5:3];
    assign ry         = ir[2:0];
    assign is_alu     = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

    always_ff @(posedge clk_addr or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            addr  <= '0;
            ir    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (run) state <= DECODE;
                end
                DECODE: begin
                    ir    <= DIN[DATA_WIDTH-1 -: 9];
                    addr  <= addr + ADDR_WIDTH'(1);
                    state <= T1;
                end
                T1: begin
                    if (opcode == OP_HALT)
                        state <= HALT;
                    else if (opcode == OP_MVI || is_alu)
                        state <= T2;
                    else
                        state <= FETCH;
                end
                T2: begin
                    // The mvi immediate has been consumed, so step past it.
                    if (opcode == OP_MVI) begin
                        addr  <= addr + ADDR_WIDTH'(1);
                        state <= FETCH;
                    end else begin
                        state <= T3;
                    end
                end
                T3:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Strobes decode straight from state and IR, so reset clears them without waiting for a clock.
    always_comb begin
        IR_in   = 1'b0;
        R_in    = 8'h00;
        R_out   = 8'h00;
        DIN_out = 1'b0;
        G_out   = 1'b0;
        A_in    = 1'b0;
        G_in    = 1'b0;
        alu_op  = 2'b00;
        done    = 1'b0;
        halted  = 1'b0;
        case (state)
            DECODE: IR_in = 1'b1;
            T1: begin
                if (opcode == OP_MV) begin
                    R_out = 8'b1 << ry;
                    R_in  = 8'b1 << rx;
                    done  = 1'b1;
                end else if (is_alu) begin
                    R_out = 8'b1 << rx;
                    A_in  = 1'b1;
                end else if (opcode != OP_MVI && opcode != OP_HALT) begin
                    done = 1'b1;
                end
            end
            T2: begin
                if (opcode == OP_MVI) begin
                    DIN_out = 1'b1;
                    R_in    = 8'b1 << rx;
                    done    = 1'b1;
                end else if (is_alu) begin
                    R_out = 8'b1 << ry;
                    G_in  = 1'b1;
                    if (opcode == OP_SUB)
                        alu_op = 2'b01;
                    else if (opcode == OP_AND)
                        alu_op = 2'b10;
                end
            end
            T3: begin
                if (is_alu) begin
                    G_out = 1'b1;
                    R_in  = 8'b1 << rx;
                    done  = 1'b1;
                end
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule
